// File: rtl/main_control.sv
// Main control decoder for a single-issue MIPS-subset CPU.
// The opcode is decoded into datapath strobes and an ALU-op class. All outputs
// are registered, so they appear one clock after the opcode is sampled.
// flush inserts a bubble, hold freezes the outputs, and an unsupported opcode
// raises illegal_op.
module main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       op_valid,
    input  logic       hold,
    input  logic       flush,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic       Branch,
    output logic [1:0] ALUctr,
    output logic       ctrl_valid,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    // The bubble value is all zeros. This keeps the write/read enables inactive.
    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_ctr;
        logic       ctrl_valid;
        logic       illegal_op;
    } ctrl_t;

    ctrl_t decode_w;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Decode the opcode into a control word. A non-valid slot decodes to a bubble.
    always_comb begin
        decode_w = '0;
        if (op_valid) begin
            decode_w.ctrl_valid = 1'b1;
            unique case (op)
                OP_RTYPE: begin
                    decode_w.reg_dst   = 1'b1;
                    decode_w.reg_write = 1'b1;
                    decode_w.alu_ctr   = ALU_R;
                end
                OP_LW: begin
                    decode_w.reg_write  = 1'b1;
                    decode_w.alu_src    = 1'b1;
                    decode_w.mem_read   = 1'b1;
                    decode_w.mem_to_reg = 1'b1;
                    decode_w.alu_ctr    = ALU_ADD;
                end
                OP_SW: begin
                    decode_w.alu_src   = 1'b1;
                    decode_w.mem_write = 1'b1;
                    decode_w.alu_ctr   = ALU_ADD;
                end
                OP_BEQ: begin
                    decode_w.branch  = 1'b1;
                    decode_w.alu_ctr = ALU_SUB;
                end
                OP_LUI: begin
                    decode_w.reg_write = 1'b1;
                    decode_w.alu_src   = 1'b1;
                    decode_w.alu_ctr   = ALU_LUI;
                end
                default: begin
                    decode_w.illegal_op = 1'b1;
                end
            endcase
        end
    end

    // Select the next control word. flush has priority over hold, and hold has priority over decode.
    always_comb begin
        ctrl_d = decode_w;
        if (flush) begin
            ctrl_d = '0;
        end else if (hold) begin
            ctrl_d = ctrl_q;
        end
    end

    // Control register. Asynchronous reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegDst     = ctrl_q.reg_dst;
    assign RegWrite   = ctrl_q.reg_write;
    assign ALUSrc     = ctrl_q.alu_src;
    assign MemWrite   = ctrl_q.mem_write;
    assign MemRead    = ctrl_q.mem_read;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign Branch     = ctrl_q.branch;
    assign ALUctr     = ctrl_q.alu_ctr;
    assign ctrl_valid = ctrl_q.ctrl_valid;
    assign illegal_op = ctrl_q.illegal_op;

endmodule

// File: tb/tb_main_control.sv
// Directed, table-driven bench for main_control.
// Each expected word is hand-coded from the decode table. The word is packed as
// {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemtoReg,Branch,ALUctr[1:0],ctrl_valid,illegal_op}.
module tb_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       op_valid;
    logic       hold;
    logic       flush;
    logic       RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch;
    logic [1:0] ALUctr;
    logic       ctrl_valid, illegal_op;

    int n_vec;
    int n_err;

    main_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .op_valid   (op_valid),
        .hold       (hold),
        .flush      (flush),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .MemtoReg   (MemtoReg),
        .Branch     (Branch),
        .ALUctr     (ALUctr),
        .ctrl_valid (ctrl_valid),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control words, hand-derived from the decode table.
    localparam logic [10:0] W_BUB = 11'b000_0000_00_00;
    localparam logic [10:0] W_R   = 11'b110_0000_10_10;
    localparam logic [10:0] W_LW  = 11'b011_0110_00_10;
    localparam logic [10:0] W_SW  = 11'b001_1000_00_10;
    localparam logic [10:0] W_BEQ = 11'b000_0001_01_10;
    localparam logic [10:0] W_LUI = 11'b011_0000_11_10;
    localparam logic [10:0] W_ILL = 11'b000_0000_00_11;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        op_valid;
        logic        hold;
        logic        flush;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] got_word();
        return {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch,
                ALUctr, ctrl_valid, illegal_op};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = got_word();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end else begin
            $display("ok   %s: %b", name, got);
        end
        // Structural exclusions that must hold for every output word.
        if ((MemRead && MemWrite) || (RegWrite && (MemWrite || Branch))) begin
            n_err++;
            $display("FAIL %s-exclusive: got %b expected no conflicting strobes", name, got);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic v, input logic h, input logic f);
        op       = o;
        op_valid = v;
        hold     = h;
        flush    = f;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // The rows are applied in order. Each hold row expects the word held from the previous row.
        vecs.push_back('{"rtype",        6'b000000, 1'b1, 1'b0, 1'b0, W_R});
        vecs.push_back('{"lw",           6'b100011, 1'b1, 1'b0, 1'b0, W_LW});
        vecs.push_back('{"sw",           6'b101011, 1'b1, 1'b0, 1'b0, W_SW});
        vecs.push_back('{"beq",          6'b000100, 1'b1, 1'b0, 1'b0, W_BEQ});
        vecs.push_back('{"lui",          6'b001111, 1'b1, 1'b0, 1'b0, W_LUI});
        vecs.push_back('{"illegal_3f",   6'b111111, 1'b1, 1'b0, 1'b0, W_ILL});
        vecs.push_back('{"illegal_j",    6'b000010, 1'b1, 1'b0, 1'b0, W_ILL});
        vecs.push_back('{"lw_reload",    6'b100011, 1'b1, 1'b0, 1'b0, W_LW});
        vecs.push_back('{"hold1",        6'b000100, 1'b1, 1'b1, 1'b0, W_LW});
        vecs.push_back('{"hold2",        6'b000100, 1'b1, 1'b1, 1'b0, W_LW});
        vecs.push_back('{"hold3",        6'b000100, 1'b1, 1'b1, 1'b0, W_LW});
        vecs.push_back('{"unhold_beq",   6'b000100, 1'b1, 1'b0, 1'b0, W_BEQ});
        vecs.push_back('{"flush_hold",   6'b100011, 1'b1, 1'b1, 1'b1, W_BUB});
        vecs.push_back('{"hold_bubble",  6'b001111, 1'b1, 1'b1, 1'b0, W_BUB});
        vecs.push_back('{"lui2",         6'b001111, 1'b1, 1'b0, 1'b0, W_LUI});
        vecs.push_back('{"flush_only",   6'b000000, 1'b1, 1'b0, 1'b1, W_BUB});
        vecs.push_back('{"rtype2",       6'b000000, 1'b1, 1'b0, 1'b0, W_R});
        vecs.push_back('{"invalid_sw",   6'b101011, 1'b0, 1'b0, 1'b0, W_BUB});
        vecs.push_back('{"invalid_ill",  6'b111111, 1'b0, 1'b0, 1'b0, W_BUB});
        vecs.push_back('{"hold_illegal", 6'b111111, 1'b1, 1'b0, 1'b0, W_ILL});
        vecs.push_back('{"hold_keep_il", 6'b000000, 1'b1, 1'b1, 1'b0, W_ILL});

        // Reset is asserted with an R-type already presented at the inputs.
        rst_n = 1'b0;
        drive(6'b000000, 1'b1, 1'b0, 1'b0);
        #1;
        check("reset_async", W_BUB);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_over_edges", W_BUB);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_rtype", W_R);

        // Table-driven section.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].op_valid, vecs[i].hold, vecs[i].flush);
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // Mid-cycle reset: sw is loaded, the slot is invalidated, then reset is pulsed between edges.
        @(negedge clk);
        drive(6'b101011, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_sw", W_SW);
        @(negedge clk);
        drive(6'b101011, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("opvalid0_sw", W_BUB);
        @(negedge clk);
        drive(6'b100011, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_lw", W_LW);
        #2;
        rst_n = 1'b0;
        #1;
        check("midcycle_reset", W_BUB);
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'b001111, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_lui", W_LUI);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
